// File: rtl/sm_twi_defs.sv
// sm_twi_defs
//   Shared definitions for the two-port TWI master arbiter.
//   - state_t   : arbiter FSM encodings
//   - twi_cmd_t : byte command as forwarded to the engine
//                 [10] start, [9] stop, [8] rw, [7:0] wdata
//   - ABORT_CMD : command driven when a stalled owner is cut off
//   - DEF_TOUT  : default hold-timeout in clock cycles
package sm_twi_defs;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT       = 3'd2,
        ST_HOLD       = 3'd3,
        ST_ABORT      = 3'd4,
        ST_ABORT_WAIT = 3'd5
    } state_t;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       rw;
        logic [7:0] wdata;
    } twi_cmd_t;

    // A bare STOP with no data phase; releases the bus on the wire.
    localparam twi_cmd_t ABORT_CMD = '{start: 1'b0, stop: 1'b1, rw: 1'b0, wdata: 8'h00};

    localparam logic [15:0] DEF_TOUT = 16'd1000;

endpackage

// File: rtl/sm_twi_rr_sel.sv
// sm_twi_rr_sel
//   Two-way round-robin selector, purely combinational.
//   Ports:
//     eligible[1:0]  requesters allowed to win this cycle
//     pointer        requester favoured on a tie
//     advance        a transaction is finishing; move the pointer
//     last           requester that owned the finishing transaction
//     grant[1:0]     one-hot winner (zero when nobody is eligible)
//     pointer_next   pointer value for the next cycle
module sm_twi_rr_sel (
    input  logic [1:0] eligible,
    input  logic       pointer,
    input  logic       advance,
    input  logic       last,
    output logic [1:0] grant,
    output logic       pointer_next
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant        = 2'b00;
        pointer_next = pointer;
        unique case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        // Favour whoever did not just own the bus.
        if (advance) pointer_next = ~last;
    end

endmodule

// File: rtl/sm_twi_arb.sv
// sm_twi_arb
//   Shares one byte-level TWI master engine between requester 0 (CPU bridge)
//   and requester 1 (sensor poller). Ownership spans START..STOP; a stalled
//   owner is cut off with a forced STOP after TOUT idle hold cycles.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     req_valid/ready[1:0]      per-requester command handshake
//     req_start/stop/rw[1:0]    per-requester command fields
//     req_wdata[15:0]           write bytes, [7:0] req 0, [15:8] req 1
//     rsp_valid[1:0]            one-cycle result pulse to the owner
//     rsp_rdata, rsp_ack        result byte / slave ACK, valid with rsp_valid
//     m_cmd_valid/ready         command handshake to the engine
//     m_start/stop/rw, m_wdata  forwarded command fields
//     m_done, m_rdata, m_ack    engine completion and result
//     busy                      arbiter not idle
//     tout                      one-cycle pulse when a forced STOP completes
module sm_twi_arb
    import sm_twi_defs::*;
#(
    parameter int                TOUT_W = 16,
    parameter logic [TOUT_W-1:0] TOUT   = TOUT_W'(DEF_TOUT)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_start,
    input  logic [1:0]  req_stop,
    input  logic [1:0]  req_rw,
    input  logic [15:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_ack,
    output logic        m_cmd_valid,
    input  logic        m_cmd_ready,
    output logic        m_start,
    output logic        m_stop,
    output logic        m_rw,
    output logic [7:0]  m_wdata,
    input  logic        m_done,
    input  logic [7:0]  m_rdata,
    input  logic        m_ack,
    output logic        busy,
    output logic        tout
);

    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT - TOUT_W'(1);

    state_t            state_q, state_d;
    twi_cmd_t          cmd_q, m_cmd;
    logic              owner_q;
    logic              ptr_q, ptr_next;
    logic [TOUT_W-1:0] cnt_q, cnt_d;
    logic [1:0]        rsp_valid_q;
    logic [7:0]        rsp_rdata_q;
    logic              rsp_ack_q, tout_q;

    logic [1:0] eligible, grant, owner_mask;
    logic       accept, advance, rsp_fire, tout_fire, gidx;

    assign owner_mask = owner_q ? 2'b10 : 2'b01;
    assign gidx       = grant[1];

    // New transactions need START in IDLE; during HOLD only the owner may
    // continue, with or without a repeated START.
    always_comb begin
        eligible = 2'b00;
        if (state_q == ST_IDLE)      eligible = req_valid & req_start;
        else if (state_q == ST_HOLD) eligible = req_valid & owner_mask;
    end

    sm_twi_rr_sel u_rr_sel (
        .eligible     (eligible),
        .pointer      (ptr_q),
        .advance      (advance),
        .last         (owner_q),
        .grant        (grant),
        .pointer_next (ptr_next)
    );

    assign accept    = (|grant) && !rst;
    assign req_ready = accept ? grant : 2'b00;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        advance     = 1'b0;
        rsp_fire    = 1'b0;
        tout_fire   = 1'b0;
        m_cmd_valid = 1'b0;
        m_cmd       = twi_cmd_t'('0);
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                m_cmd_valid = 1'b1;
                m_cmd       = cmd_q;
                if (m_cmd_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_done) begin
                    rsp_fire = 1'b1;
                    if (cmd_q.stop) begin
                        state_d = ST_IDLE;
                        advance = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            ST_HOLD: begin
                // An owner command on the last allowed cycle beats the timeout.
                if (accept)                  state_d = ST_ISSUE;
                else if (cnt_q == TOUT_LAST) state_d = ST_ABORT;
                else                         cnt_d   = cnt_q + TOUT_W'(1);
            end
            ST_ABORT: begin
                m_cmd_valid = 1'b1;
                m_cmd       = ABORT_CMD;
                if (m_cmd_ready) state_d = ST_ABORT_WAIT;
            end
            ST_ABORT_WAIT: begin
                if (m_done) begin
                    tout_fire = 1'b1;
                    state_d   = ST_IDLE;
                    advance   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= twi_cmd_t'('0);
            owner_q     <= 1'b0;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 8'h00;
            rsp_ack_q   <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_next;
            rsp_valid_q <= rsp_fire ? owner_mask : 2'b00;
            tout_q      <= tout_fire;
            if (rsp_fire) begin
                rsp_rdata_q <= m_rdata;
                rsp_ack_q   <= m_ack;
            end
            if (accept) begin
                owner_q <= gidx;
                cmd_q   <= '{start: req_start[gidx], stop: req_stop[gidx],
                             rw: req_rw[gidx], wdata: req_wdata[8*gidx +: 8]};
            end
        end
    end

    assign m_start   = m_cmd.start;
    assign m_stop    = m_cmd.stop;
    assign m_rw      = m_cmd.rw;
    assign m_wdata   = m_cmd.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_ack   = rsp_ack_q;
    assign busy      = (state_q != ST_IDLE);
    assign tout      = tout_q;

endmodule

// File: tb/tb_sm_twi_arb.sv
// tb_sm_twi_arb
//   Directed bench for sm_twi_arb with a hand-driven engine and TOUT = 8.
//   Inputs change #1 after the rising edge; outputs are checked before the
//   next edge.
module tb_sm_twi_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_start, req_stop, req_rw;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_ack;
    logic        m_cmd_valid, m_cmd_ready, m_start, m_stop, m_rw;
    logic [7:0]  m_wdata, m_rdata;
    logic        m_done, m_ack, busy, tout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sm_twi_arb #(.TOUT_W(16), .TOUT(16'd8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_start   (req_start),
        .req_stop    (req_stop),
        .req_rw      (req_rw),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_ack     (rsp_ack),
        .m_cmd_valid (m_cmd_valid),
        .m_cmd_ready (m_cmd_ready),
        .m_start     (m_start),
        .m_stop      (m_stop),
        .m_rw        (m_rw),
        .m_wdata     (m_wdata),
        .m_done      (m_done),
        .m_rdata     (m_rdata),
        .m_ack       (m_ack),
        .busy        (busy),
        .tout        (tout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] all_outputs();
        return {req_ready, rsp_valid, rsp_rdata, rsp_ack, m_cmd_valid,
                m_start, m_stop, m_rw, m_wdata, busy, tout};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_start = '0; req_stop = '0; req_rw = '0; req_wdata = '0;
        m_cmd_ready = 1'b0; m_done = 1'b0; m_rdata = '0; m_ack = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
    endtask

    // Engine side: expects the command to be on the bus now, holds ready low
    // for rdly cycles, then finishes lat cycles after the handshake.
    task automatic xfer(input logic es, input logic ep, input logic er, input logic [7:0] ewd,
                        input logic [7:0] rd, input logic ack, input int rdly, input int lat,
                        input string tag);
        for (int i = 0; i <= rdly; i++) begin
            check({tag, "_cmd_valid"}, m_cmd_valid, 1);
            check({tag, "_cmd"}, {m_start, m_stop, m_rw, m_wdata}, {es, ep, er, ewd});
            if (i == rdly) m_cmd_ready = 1'b1;
            cycle();
        end
        m_cmd_ready = 1'b0;
        #1;
        check({tag, "_cmd_drop"}, m_cmd_valid, 0);
        repeat (lat) cycle();
        m_done = 1'b1; m_rdata = rd; m_ack = ack;
        #1;
        check({tag, "_no_early_rsp"}, rsp_valid, 0);
        cycle();
        m_done = 1'b0; m_rdata = '0; m_ack = 1'b0;
        #1;
    endtask

    // One full byte transaction by port p: accept, forward, result.
    task automatic txn(input int p, input logic st, input logic sp, input logic r,
                       input logic [7:0] wd, input logic [7:0] rd, input logic ack,
                       input int rdly, input int lat, input string tag);
        req_valid[p] = 1'b1; req_start[p] = st; req_stop[p] = sp; req_rw[p] = r;
        req_wdata[8*p +: 8] = wd;
        #1;
        check({tag, "_ready"}, req_ready, 32'(1) << p);
        cycle();
        req_valid[p] = 1'b0;
        #1;
        xfer(st, sp, r, wd, rd, ack, rdly, lat, tag);
        check({tag, "_rsp_valid"}, rsp_valid, 32'(1) << p);
        check({tag, "_rsp"}, {rsp_rdata, rsp_ack}, {rd, ack});
    endtask

    initial begin
        do_reset();
        check("reset_outputs", all_outputs(), 0);

        // Single write with a delayed engine ready.
        txn(0, 1, 1, 0, 8'hA5, 8'h00, 1, 2, 19, "single_write");
        check("single_write_idle", busy, 0);
        cycle();
        check("single_write_pulse_end", rsp_valid, 0);

        // Simultaneous starts after reset: port 0 first, then port 1.
        do_reset();
        req_valid[1] = 1'b1; req_start[1] = 1'b1; req_stop[1] = 1'b1;
        req_rw[1] = 1'b0; req_wdata[15:8] = 8'h5A;
        txn(0, 1, 1, 0, 8'h11, 8'h00, 1, 0, 3, "pair_a0");
        txn(1, 1, 1, 0, 8'h5A, 8'h00, 1, 0, 3, "pair_a1");
        // Port 0 alone leaves the pointer on port 1.
        txn(0, 1, 1, 0, 8'h22, 8'h00, 1, 0, 2, "pair_solo0");
        req_valid[0] = 1'b1; req_start[0] = 1'b1; req_stop[0] = 1'b1;
        req_rw[0] = 1'b0; req_wdata[7:0] = 8'h33;
        txn(1, 1, 1, 0, 8'h44, 8'h00, 1, 0, 2, "pair_b1");
        txn(0, 1, 1, 0, 8'h33, 8'h00, 1, 0, 2, "pair_b0");

        // Multi-byte read by port 1 while port 0 keeps requesting.
        // The address write is NACKed and must not release the bus.
        req_valid[0] = 1'b1; req_start[0] = 1'b1; req_stop[0] = 1'b1;
        req_rw[0] = 1'b0; req_wdata[7:0] = 8'h66;
        req_valid[1] = 1'b1; req_start[1] = 1'b1;
        #1;
        txn(1, 1, 0, 0, 8'h90, 8'h00, 0, 0, 2, "mb_addr");
        check("mb_hold_busy", busy, 1);
        txn(1, 1, 0, 1, 8'h00, 8'h11, 1, 0, 2, "mb_rs_read");
        txn(1, 0, 1, 1, 8'h00, 8'h3C, 1, 0, 2, "mb_last_read");
        txn(0, 1, 1, 0, 8'h66, 8'h00, 1, 0, 2, "mb_release");

        // Timeout: port 0 opens a transaction and stalls.
        do_reset();
        txn(0, 1, 0, 0, 8'h12, 8'h00, 1, 0, 2, "to_open");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_hold_%0d", i), {busy, m_cmd_valid}, 2'b10);
            cycle();
        end
        xfer(0, 1, 0, 8'h00, 8'hEE, 1, 0, 3, "to_abort");
        check("to_pulse", {tout, rsp_valid, busy}, 4'b1000);
        cycle();
        check("to_pulse_end", tout, 0);

        // Owner command on the final allowed hold cycle wins over the timeout.
        do_reset();
        txn(0, 1, 0, 0, 8'h21, 8'h00, 1, 0, 2, "co_open");
        repeat (7) cycle();
        txn(0, 0, 1, 1, 8'h00, 8'h7E, 1, 0, 2, "co_last");
        check("co_no_tout", tout, 0);
        cycle();
        check("co_no_tout_later", {tout, busy}, 0);

        // Reset while waiting for the engine.
        req_valid[0] = 1'b1; req_start[0] = 1'b1; req_stop[0] = 1'b1;
        req_rw[0] = 1'b0; req_wdata[7:0] = 8'h55;
        cycle();
        req_valid[0] = 1'b0;
        m_cmd_ready = 1'b1;
        cycle();
        m_cmd_ready = 1'b0;
        rst = 1'b1;
        cycle();
        check("rst_outputs", all_outputs(), 0);
        rst = 1'b0;
        m_done = 1'b1; m_rdata = 8'hBB; m_ack = 1'b1;
        cycle();
        m_done = 1'b0; m_rdata = '0; m_ack = 1'b0;
        #1;
        check("rst_done_ignored", all_outputs(), 0);
        txn(0, 1, 1, 0, 8'h77, 8'h00, 1, 0, 2, "rst_fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sm_twi_arb.md
Name: sm_twi_arb

Overview:
- Shares one byte-level TWI master engine between two requesters, the CPU bus bridge (port 0) and a hardware sensor poller (port 1).
- Grants the bus for a whole TWI transaction, from START to STOP, and forwards each byte command to the engine.
- Returns the engine's result to the owning requester.
- Forces a STOP if the owner stalls mid-transaction.

Parameters:
- TOUT_W, 16: width of the hold-timeout counter.
- TOUT, 16'd1000: number of idle HOLD cycles allowed before a forced STOP.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  2  command valid, one bit per requester
- req_ready  out  2  command accepted this cycle, per requester
- req_start  in  2  command begins with (repeated) START
- req_stop  in  2  command ends with STOP
- req_rw  in  2  1 = read byte, 0 = write byte
- req_wdata  in  16  write byte; [7:0] requester 0, [15:8] requester 1
- rsp_valid  out  2  one-cycle result pulse, per requester
- rsp_rdata  out  8  read byte, valid with rsp_valid
- rsp_ack  out  1  slave ACK observed, valid with rsp_valid
- m_cmd_valid  out  1  command to engine
- m_cmd_ready  in  1  engine accepts command
- m_start, m_stop, m_rw  out  1 each  forwarded command fields
- m_wdata  out  8  forwarded write byte
- m_done  in  1  one-cycle engine completion pulse
- m_rdata  in  8  engine read byte
- m_ack  in  1  engine ACK result
- busy  out  1  state != IDLE
- tout  out  1  one-cycle pulse when a forced STOP completes

Behaviour:
- Reset: state IDLE, owner 0, round-robin pointer favouring requester 0, counter 0. All outputs 0.
- States: IDLE, ISSUE, WAIT, HOLD, ABORT, ABORT_WAIT.
- IDLE:
  - A requester is eligible only if req_valid && req_start.
  - If both are eligible, grant the one favoured by the pointer.
  - Assert req_ready[g] combinationally in the same cycle.
  - Latch start/stop/rw/wdata, set owner = g, go to ISSUE.
  - A request without start is never accepted in IDLE; its req_ready stays 0.
- ISSUE:
  - Drive m_cmd_valid = 1 with the latched fields, held stable until m_cmd_ready.
  - On the handshake cycle go to WAIT.
- WAIT:
  - On m_done, pulse rsp_valid[owner] the next cycle, with rsp_rdata = m_rdata and rsp_ack = m_ack registered.
  - If the latched stop = 1: go to IDLE and point round-robin at the other requester.
  - Otherwise go to HOLD with counter = 0.
- HOLD:
  - Only the owner is accepted; start is allowed (repeated START).
  - Acceptance is the same as in IDLE: req_ready pulse, latch, go to ISSUE.
  - The non-owner's req_ready stays 0.
  - The counter increments every HOLD cycle without an owner command.
  - At TOUT-1 with no owner valid, go to ABORT.
  - If owner valid and the limit coincide, the command wins.
- ABORT:
  - Drive m_cmd_valid with start = 0, stop = 1, rw = 0, wdata = 0.
  - On the handshake go to ABORT_WAIT.
- ABORT_WAIT:
  - On m_done, pulse tout for one cycle.
  - Send no rsp_valid.
  - Go to IDLE; the pointer moves away from the aborted owner.
- m_done outside WAIT/ABORT_WAIT is ignored. A write NACK does not release the bus.
- Latency, best case:
  - Accept at cycle T; m_cmd_valid at T+1.
  - rsp_valid one cycle after m_done.
- Reset mid-transaction:
  - The arbiter returns to IDLE.
  - The engine is reset by the same rst.
  - No STOP is generated.

Decomposition:
- Shared include/package sm_twi_defs: state encodings, command field bit positions, default TOUT.
- One sub-module, sm_twi_rr_sel: 2-way round-robin selector.
  - Inputs: eligible[1:0], pointer, advance.
  - Outputs: grant one-hot, updated pointer.

Test Plan:
- Single write: req0 start = 1, stop = 1, wdata 8'hA5; engine done after 20 cycles with ack = 1.
  - Expect: req_ready[0] at T; m_cmd_valid at T+1 with m_wdata = A5; rsp_valid[0] and rsp_ack = 1 the cycle after m_done; busy 0 afterwards.
- Simultaneous start on both ports after reset.
  - Expect: port 0 granted first; port 1 waits with ready = 0; port 1 is granted immediately after port 0's stop completes.
  - Repeat the pair: port 1 is now favoured.
- Multi-byte read by req1: write address (start), repeated-start read, final read with stop, m_rdata 8'h3C.
  - Expect: three rsp_valid[1] pulses with the last rsp_rdata = 3C; req0 remains blocked throughout HOLD.
- Timeout with TOUT = 8: req0 issues start without stop, then idles.
  - Expect: after 8 HOLD cycles, m_cmd_valid with m_stop = 1, m_start = 0; tout pulses after m_done; no rsp_valid; state IDLE.
- Coincidence: owner req_valid arrives exactly at counter TOUT-1.
  - Expect: the command is accepted, no abort, and tout stays 0.
- rst asserted during WAIT.
  - Expect: all outputs 0 next cycle; a following m_done is ignored; a fresh req0 start is accepted normally.
